// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered UART transmitter with transmit FIFO and valid/ready input
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   data        word to enqueue (DataBits wide)
//   valid       data is valid this cycle
//   ready       FIFO can accept; a word transfers when valid && ready at posedge
//   tx          registered UART line, idle high
//   busy        high while the FIFO holds words or a frame is on the line
//   fifo_count  FIFO occupancy, not counting the word in the shifter

module uart_tx_buffered #(
   parameter int ClockFrequencyHz = 66_000_000,
   parameter int BaudRate         = 9600,
   parameter int DataBits         = 8,
   parameter int Parity           = 0,
   parameter int StopBits         = 1,
   parameter int FifoDepth        = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DataBits-1:0]          data,
   input  logic                         valid,
   output logic                         ready,
   output logic                         tx,
   output logic                         busy,
   output logic [$clog2(FifoDepth):0]   fifo_count
);

   localparam int BIT_TIME = ClockFrequencyHz / BaudRate;
   localparam int CNT_W    = $clog2(BIT_TIME);
   localparam int AW       = $clog2(FifoDepth);
   localparam int PW       = AW + 1;
   localparam int IDX_W    = $clog2(DataBits);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TIME - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DataBits - 1);
   localparam logic             STOP_LAST = (StopBits == 2);
   localparam logic             PAR_ODD   = (Parity == 2);
   localparam logic             HAS_PAR   = (Parity != 0);

   if (BIT_TIME < 2) begin : g_chk_bit_time
      $error("uart_tx_buffered: ClockFrequencyHz / BaudRate must be >= 2");
   end
   if (DataBits < 5 || DataBits > 9) begin : g_chk_data_bits
      $error("uart_tx_buffered: DataBits must be 5..9");
   end
   if (Parity < 0 || Parity > 2) begin : g_chk_parity
      $error("uart_tx_buffered: Parity must be 0, 1 or 2");
   end
   if (StopBits != 1 && StopBits != 2) begin : g_chk_stop_bits
      $error("uart_tx_buffered: StopBits must be 1 or 2");
   end
   if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_chk_depth
      $error("uart_tx_buffered: FifoDepth must be a power of two >= 2");
   end

   // ------------------------------------------------------------------
   // Transmit FIFO. Pointers carry one extra MSB so full and empty are
   // distinguishable when the index bits match.
   // ------------------------------------------------------------------
   logic [DataBits-1:0] mem [FifoDepth];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic                empty;
   logic                full;
   logic                push;
   logic                pop;
   logic [DataBits-1:0] head;

   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   // ready looks only at the pointers: a pop in the same cycle does not
   // open a slot for a write until the following cycle.
   assign ready      = !full;
   assign push       = valid && ready;
   assign head       = mem[rd_ptr[AW-1:0]];
   assign fifo_count = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= data;
      end
   end

   // ------------------------------------------------------------------
   // Frame sequencer
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t              state;
   logic [DataBits-1:0] shift;
   logic                parity_bit;
   logic [CNT_W-1:0]    bit_cnt;
   logic [IDX_W-1:0]    data_idx;
   logic                stop_idx;
   logic                stop_done;
   logic                line_bit;

   // Last cycle of the last stop bit: the next word is loaded here so the
   // following start bit begins without an idle cycle.
   assign stop_done = (state == S_STOP) && (bit_cnt == '0) && (stop_idx == STOP_LAST);
   assign pop       = !empty && ((state == S_IDLE) || stop_done);

   // Line level for the current state; tx registers it one cycle later,
   // so tx lags the state by exactly one clock.
   always_comb begin
      line_bit = 1'b1;
      case (state)
         S_START:  line_bit = 1'b0;
         S_DATA:   line_bit = shift[0];
         S_PARITY: line_bit = parity_bit;
         default:  line_bit = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         tx         <= 1'b1;
         busy       <= 1'b0;
         shift      <= '0;
         parity_bit <= 1'b0;
         bit_cnt    <= '0;
         data_idx   <= '0;
         stop_idx   <= 1'b0;
      end else begin
         tx <= line_bit;
         // Registered from the pre-edge state, so busy drops in the same
         // cycle the delayed tx finishes its final stop bit.
         busy <= (state != S_IDLE) || !empty;

         if (pop) begin
            shift      <= head;
            parity_bit <= (^head) ^ PAR_ODD;
            bit_cnt    <= BIT_LAST;
            state      <= S_START;
         end else begin
            case (state)
               S_START: begin
                  if (bit_cnt == '0) begin
                     bit_cnt  <= BIT_LAST;
                     data_idx <= '0;
                     state    <= S_DATA;
                  end else begin
                     bit_cnt <= bit_cnt - CNT_W'(1);
                  end
               end
               S_DATA: begin
                  if (bit_cnt == '0) begin
                     bit_cnt <= BIT_LAST;
                     shift   <= shift >> 1;
                     if (data_idx == DATA_LAST) begin
                        stop_idx <= 1'b0;
                        state    <= HAS_PAR ? S_PARITY : S_STOP;
                     end else begin
                        data_idx <= data_idx + IDX_W'(1);
                     end
                  end else begin
                     bit_cnt <= bit_cnt - CNT_W'(1);
                  end
               end
               S_PARITY: begin
                  if (bit_cnt == '0) begin
                     bit_cnt  <= BIT_LAST;
                     stop_idx <= 1'b0;
                     state    <= S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt - CNT_W'(1);
                  end
               end
               S_STOP: begin
                  if (bit_cnt == '0) begin
                     if (stop_idx == STOP_LAST) begin
                        state <= S_IDLE;
                     end else begin
                        stop_idx <= 1'b1;
                        bit_cnt  <= BIT_LAST;
                     end
                  end else begin
                     bit_cnt <= bit_cnt - CNT_W'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed self-checking bench for uart_tx_buffered

module tb_uart_tx_buffered;

   localparam int BT    = 10;
   localparam int LOG_N = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [7:0] d8;   logic v8;   logic r8;   logic t8;   logic b8;   logic [2:0] c8;
   logic [6:0] d7e;  logic v7e;  logic r7e;  logic t7e;  logic b7e;  logic [2:0] c7e;
   logic [6:0] d7o;  logic v7o;  logic r7o;  logic t7o;  logic b7o;  logic [2:0] c7o;
   logic [8:0] d9;   logic v9;   logic r9;   logic t9;   logic b9;   logic [2:0] c9;

   uart_tx_buffered #(.ClockFrequencyHz(10), .BaudRate(1), .DataBits(8), .Parity(0),
                      .StopBits(1), .FifoDepth(4)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .data(d8), .valid(v8), .ready(r8),
      .tx(t8), .busy(b8), .fifo_count(c8));

   uart_tx_buffered #(.ClockFrequencyHz(10), .BaudRate(1), .DataBits(7), .Parity(1),
                      .StopBits(2), .FifoDepth(4)) u_7e2 (
      .clk(clk), .rst_n(rst_n), .data(d7e), .valid(v7e), .ready(r7e),
      .tx(t7e), .busy(b7e), .fifo_count(c7e));

   uart_tx_buffered #(.ClockFrequencyHz(10), .BaudRate(1), .DataBits(7), .Parity(2),
                      .StopBits(2), .FifoDepth(4)) u_7o2 (
      .clk(clk), .rst_n(rst_n), .data(d7o), .valid(v7o), .ready(r7o),
      .tx(t7o), .busy(b7o), .fifo_count(c7o));

   uart_tx_buffered #(.ClockFrequencyHz(10), .BaudRate(1), .DataBits(9), .Parity(0),
                      .StopBits(1), .FifoDepth(4)) u_9n1 (
      .clk(clk), .rst_n(rst_n), .data(d9), .valid(v9), .ready(r9),
      .tx(t9), .busy(b9), .fifo_count(c9));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       tx_log   [4][LOG_N];
   logic       busy_log [4][LOG_N];
   logic [2:0] cnt8_log [LOG_N];
   logic       rdy8_log [LOG_N];

   always @(negedge clk) begin
      if (cyc < LOG_N) begin
         tx_log[0][cyc]   = t8;   busy_log[0][cyc] = b8;
         tx_log[1][cyc]   = t7e;  busy_log[1][cyc] = b7e;
         tx_log[2][cyc]   = t7o;  busy_log[2][cyc] = b7o;
         tx_log[3][cyc]   = t9;   busy_log[3][cyc] = b9;
         cnt8_log[cyc]    = c8;
         rdy8_log[cyc]    = r8;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, idx, obs, exp);
      end
   endtask

   function automatic logic ready_of(input int sel);
      case (sel)
         0:       return r8;
         1:       return r7e;
         2:       return r7o;
         default: return r9;
      endcase
   endfunction

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Called at a negedge; holds valid until the word is taken and returns
   // the index of the accepting posedge.
   task automatic drive(input int sel, input logic [8:0] d, output int acc);
      acc = -1;
      case (sel)
         0:       begin d8  = d[7:0]; v8  = 1'b1; end
         1:       begin d7e = d[6:0]; v7e = 1'b1; end
         2:       begin d7o = d[6:0]; v7o = 1'b1; end
         default: begin d9  = d;      v9  = 1'b1; end
      endcase
      for (int i = 0; i < 1000; i++) begin
         if (ready_of(sel)) begin
            @(negedge clk);
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      chk("accept_in_time", sel, 32'(acc >= 0), 1);
   endtask

   task automatic check_frame(input int sel, input int start, input logic [15:0] bits,
                              input int nbits, input string tag);
      for (int i = 0; i < nbits * BT; i++) begin
         chk({tag, "_tx"},   i, 32'(tx_log[sel][start + i]),   32'(bits[i / BT]));
         chk({tag, "_busy"}, i, 32'(busy_log[sel][start + i]), 1);
      end
   endtask

   int n;
   int m;
   int a;
   logic [2:0] exp_cnt [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

   initial begin
      rst_n = 1'b0;
      d8 = '0; d7e = '0; d7o = '0; d9 = '0;
      v8 = 1'b0; v7e = 1'b0; v7o = 1'b0; v9 = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_tx",    0, 32'(t8), 1);
      chk("rst_ready", 0, 32'(r8), 1);
      chk("rst_busy",  0, 32'(b8), 0);
      chk("rst_count", 0, 32'(c8), 0);
      chk("rst_tx_7e", 0, 32'(t7e), 1);
      chk("rst_tx_9",  0, 32'(t9), 1);
      rst_n = 1'b1;
      @(negedge clk);

      // 8N1 single word 0x55: start at N+2, frame 100 cycles
      drive(0, 9'h055, n);
      v8 = 1'b0;
      wait_until(n + 110);
      chk("t1_busy_at_accept", n, 32'(busy_log[0][n]), 0);
      chk("t1_busy_rise",      n, 32'(busy_log[0][n + 1]), 1);
      chk("t1_tx_before",      n, 32'(tx_log[0][n + 1]), 1);
      check_frame(0, n + 2, 16'({1'b1, 8'h55, 1'b0}), 10, "t1");
      chk("t1_busy_fall", n, 32'(busy_log[0][n + 102]), 0);
      chk("t1_tx_after",  n, 32'(tx_log[0][n + 102]), 1);

      // Burst A1..A6 into a depth-4 FIFO
      drive(0, 9'h0A1, n);
      chk("burst_cnt", 0, 32'(c8), 32'(exp_cnt[0]));
      for (int k = 1; k < 5; k++) begin
         drive(0, 9'(8'hA1 + k), a);
         chk("burst_acc", k, a, n + k);
         chk("burst_cnt", k, 32'(c8), 32'(exp_cnt[k]));
      end
      chk("burst_full_ready", 0, 32'(r8), 0);
      drive(0, 9'h0A6, a);
      v8 = 1'b0;
      chk("a6_acc", 0, a, n + 102);
      chk("a6_cnt", 0, 32'(c8), 4);
      wait_until(n + 620);
      chk("pop_cycle_ready", 0, 32'(rdy8_log[n + 100]), 0);
      chk("after_pop_ready", 0, 32'(rdy8_log[n + 101]), 1);
      chk("after_pop_cnt",   0, 32'(cnt8_log[n + 101]), 3);
      for (int k = 0; k < 6; k++) begin
         check_frame(0, n + 2 + 100 * k, 16'({1'b1, 8'(8'hA1 + k), 1'b0}), 10, "burst");
      end
      chk("burst_busy_last", 0, 32'(busy_log[0][n + 601]), 1);
      chk("burst_busy_fall", 0, 32'(busy_log[0][n + 602]), 0);

      // Reset during A2's data bits with three words still queued
      drive(0, 9'h0A1, n);
      for (int k = 1; k < 5; k++) begin
         drive(0, 9'(8'hA1 + k), a);
      end
      v8 = 1'b0;
      wait_until(n + 140);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_tx",    0, 32'(t8), 1);
      chk("midrst_busy",  0, 32'(b8), 0);
      chk("midrst_count", 0, 32'(c8), 0);
      chk("midrst_ready", 0, 32'(r8), 1);
      rst_n = 1'b1;
      @(negedge clk);
      drive(0, 9'h03C, m);
      v8 = 1'b0;
      wait_until(m + 160);
      for (int c = n + 141; c <= m + 1; c++) begin
         chk("postrst_idle", c, 32'(tx_log[0][c]), 1);
      end
      check_frame(0, m + 2, 16'({1'b1, 8'h3C, 1'b0}), 10, "rst3c");
      for (int c = m + 102; c < m + 155; c++) begin
         chk("postrst_quiet_tx",   c, 32'(tx_log[0][c]), 1);
         chk("postrst_quiet_busy", c, 32'(busy_log[0][c]), 0);
      end

      // 7E2, 0x07: parity 1
      drive(1, 9'h007, n);
      v7e = 1'b0;
      wait_until(n + 125);
      chk("e_tx_before", 0, 32'(tx_log[1][n + 1]), 1);
      check_frame(1, n + 2, 16'({2'b11, 1'b1, 7'h07, 1'b0}), 11, "e72");
      chk("e_busy_fall", 0, 32'(busy_log[1][n + 112]), 0);

      // 7O2, 0x07: parity 0
      drive(2, 9'h007, n);
      v7o = 1'b0;
      wait_until(n + 125);
      check_frame(2, n + 2, 16'({2'b11, 1'b0, 7'h07, 1'b0}), 11, "o72");
      chk("o_busy_fall", 0, 32'(busy_log[2][n + 112]), 0);

      // 9N1, 0x1FF then 0x100 back to back
      drive(3, 9'h1FF, n);
      drive(3, 9'h100, a);
      v9 = 1'b0;
      chk("n9_acc2", 0, a, n + 1);
      wait_until(n + 235);
      check_frame(3, n + 2,   16'({1'b1, 9'h1FF, 1'b0}), 11, "n9a");
      check_frame(3, n + 112, 16'({1'b1, 9'h100, 1'b0}), 11, "n9b");
      chk("n9_busy_fall", 0, 32'(busy_log[3][n + 222]), 0);
      chk("n9_tx_after",  0, 32'(tx_log[3][n + 222]), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
